// File: rtl/sigma_delta_modulator.sv
// Second-order 1-bit sigma-delta modulator with a per-sample valid/ready request
// and underrun flag; each input sample is held for OSR loop iterations.
module sigma_delta_modulator #(
    parameter int N     = 8,
    parameter int OSR   = 16,
    parameter int ACC_W = N + 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] dataIn,
    input  logic         inValid,
    output logic         inReady,
    output logic         bitOut,
    output logic         underrun
);
    localparam int SW = ACC_W + 2;
    localparam int PW = (OSR > 2) ? $clog2(OSR) : 1;
    localparam logic [PW-1:0] LAST_PH = PW'(OSR - 1);

    localparam logic signed [SW-1:0] POS_LIM = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [SW-1:0] NEG_LIM = {3'b111, {(ACC_W-2){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] HALF    = {{(SW-N){1'b0}}, 1'b1, {(N-1){1'b0}}};

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                    state_q;
    logic [PW-1:0]             phase_q;
    logic [N-1:0]              sample_q;
    logic signed [ACC_W-1:0]   int1_q, int2_q;
    logic                      bit_q, underrun_q;

    logic signed [SW-1:0]      x_w, fb_w, sum1_w, sum2_w;
    logic signed [ACC_W-1:0]   int1_d, int2_d;
    logic                      last_w;

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [SW-1:0] s);
        if (s > POS_LIM)      sat = POS_LIM[ACC_W-1:0];
        else if (s < NEG_LIM) sat = NEG_LIM[ACC_W-1:0];
        else                  sat = s[ACC_W-1:0];
    endfunction

    assign last_w  = (phase_q == LAST_PH);
    assign inReady = (state_q == IDLE) || last_w;

    // Loop arithmetic is done two bits wider than the integrators so that a
    // single update can never wrap before it is clamped.
    always_comb begin
        x_w    = $signed({{(SW-N){1'b0}}, sample_q}) - HALF;
        fb_w   = bit_q ? HALF : -HALF;
        sum1_w = {{2{int1_q[ACC_W-1]}}, int1_q} + x_w - fb_w;
        sum2_w = {{2{int2_q[ACC_W-1]}}, int2_q} + {{2{int1_q[ACC_W-1]}}, int1_q} - fb_w;
        int1_d = sat(sum1_w);
        int2_d = sat(sum2_w);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            sample_q   <= '0;
            int1_q     <= '0;
            int2_q     <= '0;
            bit_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (inValid) begin
                        sample_q <= dataIn;
                        phase_q  <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    int1_q <= int1_d;
                    int2_q <= int2_d;
                    bit_q  <= ~int2_d[ACC_W-1];
                    if (last_w) begin
                        phase_q <= '0;
                        // Missed slot: keep the old sample (zero-order hold).
                        if (inValid) sample_q   <= dataIn;
                        else         underrun_q <= 1'b1;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bitOut   = bit_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_sigma_delta_modulator.sv
// Directed bench for sigma_delta_modulator: reset, exact loop trace, ones
// density, underrun, saturation and mid-run reset.
module tb_sigma_delta_modulator;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] dataIn;
    logic       inValid;
    logic       inReady, bitOut, underrun;

    int checks = 0;
    int errors = 0;

    sigma_delta_modulator #(.N(8), .OSR(16), .ACC_W(12)) dut (
        .clk(clk), .reset(reset), .dataIn(dataIn), .inValid(inValid),
        .inReady(inReady), .bitOut(bitOut), .underrun(underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // From IDLE: transfer 192 on E0, then follow six loop updates.
    task automatic do_trace(input string tag);
        int eb [6] = '{1, 1, 1, 1, 1, 0};
        int e1 [6] = '{192, 128, 64, 0, -64, -128};
        int e2 [6] = '{128, 192, 192, 128, 0, -192};
        dataIn  = 8'd192;
        inValid = 1'b1;
        step();
        chk({tag, "_e0_bit"}, 32'(bitOut), 0);
        chk({tag, "_e0_int1"}, $signed(dut.int1_q), 0);
        chk({tag, "_e0_sample"}, 32'(dut.sample_q), 192);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("%s_bit%0d", tag, i + 1), 32'(bitOut), eb[i]);
            chk($sformatf("%s_int1_%0d", tag, i + 1), $signed(dut.int1_q), e1[i]);
            chk($sformatf("%s_int2_%0d", tag, i + 1), $signed(dut.int2_q), e2[i]);
        end
    endtask

    // Run a fixed input for ncyc cycles; checks inReady period, no underrun,
    // and the ones count over the final 1024 cycles.
    task automatic run_density(input string tag, input logic [7:0] val, input int ncyc,
                               input int lo, input int hi, input logic chk_sat);
        int ones = 0, last_rdy = -1, bad_per = 0, unds = 0, bad_sat = 0;
        int p1, p2, c1, c2;
        dataIn  = val;
        inValid = 1'b1;
        p1 = $signed(dut.int1_q);
        p2 = $signed(dut.int2_q);
        for (int c = 0; c < ncyc; c++) begin
            if (inReady) begin
                if (last_rdy >= 0 && c - last_rdy != 16) bad_per++;
                last_rdy = c;
            end
            step();
            if (underrun) unds++;
            if (c >= ncyc - 1024 && bitOut) ones++;
            c1 = $signed(dut.int1_q);
            c2 = $signed(dut.int2_q);
            if (c1 > 2047 || c1 < -2047 || c2 > 2047 || c2 < -2047) bad_sat++;
            if ((p1 > 1024 && c1 < -1024) || (p1 < -1024 && c1 > 1024) ||
                (p2 > 1024 && c2 < -1024) || (p2 < -1024 && c2 > 1024)) bad_sat++;
            p1 = c1;
            p2 = c2;
        end
        chk_rng({tag, "_ones"}, ones, lo, hi);
        chk({tag, "_rdy_period_errs"}, bad_per, 0);
        chk({tag, "_underruns"}, unds, 0);
        if (chk_sat) chk({tag, "_sat_wrap_errs"}, bad_sat, 0);
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        inValid = 1'b1;
        dataIn  = 8'd192;

        // Reset with inValid held high: nothing is taken.
        for (int i = 0; i < 3; i++) step();
        chk("rst_bit", 32'(bitOut), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_inready", 32'(inReady), 1);
        chk("rst_state", 32'(dut.state_q), 0);
        chk("rst_sample", 32'(dut.sample_q), 0);
        reset   = 1'b0;
        inValid = 1'b0;
        step();
        chk("idle_state", 32'(dut.state_q), 0);
        chk("idle_bit", 32'(bitOut), 0);
        chk("idle_inready", 32'(inReady), 1);
        chk("idle_int1", $signed(dut.int1_q), 0);

        do_trace("trace");
        chk("run_inready_low", 32'(inReady), 0);

        run_density("dens64", 8'd64, 2048, 252, 260, 1'b0);
        run_density("dens128", 8'd128, 2048, 508, 516, 1'b0);
        run_density("dens192", 8'd192, 2048, 764, 772, 1'b0);

        // Underrun: skip one slot, then resume with a different sample.
        n = 0;
        while (!inReady && n < 32) begin step(); n++; end
        chk("und_found_slot", 32'(inReady), 1);
        dataIn  = 8'd100;
        inValid = 1'b0;
        step();
        chk("und_pulse", 32'(underrun), 1);
        chk("und_hold_sample", 32'(dut.sample_q), 192);
        chk("und_phase_wrap", 32'(dut.phase_q), 0);
        inValid = 1'b1;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (underrun) n++;
        end
        chk("und_one_cycle", n, 0);
        chk("und_next_slot_ready", 32'(inReady), 1);
        step();
        chk("und_resume_sample", 32'(dut.sample_q), 100);
        chk("und_resume_no_pulse", 32'(underrun), 0);
        run_density("dens100", 8'd100, 2048, 396, 404, 1'b0);

        run_density("sat0", 8'd0, 4096, 0, 8, 1'b1);
        run_density("sat255", 8'd255, 4096, 1016, 1024, 1'b1);

        // Reset mid-run at phase 7 with inValid asserted.
        n = 0;
        while (dut.phase_q != 4'd7 && n < 32) begin step(); n++; end
        chk("mid_phase7", 32'(dut.phase_q), 7);
        reset   = 1'b1;
        inValid = 1'b1;
        dataIn  = 8'd50;
        step();
        chk("mid_state", 32'(dut.state_q), 0);
        chk("mid_int1", $signed(dut.int1_q), 0);
        chk("mid_int2", $signed(dut.int2_q), 0);
        chk("mid_bit", 32'(bitOut), 0);
        chk("mid_sample", 32'(dut.sample_q), 0);
        chk("mid_inready", 32'(inReady), 1);
        reset = 1'b0;
        do_trace("retrace");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sigma_delta_modulator.md
# sigma_delta_modulator

Second-order, 1-bit sigma-delta modulator that consumes the oversampled, interpolated PCM stream from the interpolating filter and produces the single-bit DAC drive stream. It holds one input sample for OSR clock cycles, running the noise-shaping loop every clock. A valid/ready handshake requests the next sample, and the block flags any sample the upstream stage fails to deliver in time.

## Interface

- N, 8: input sample width; unsigned offset-binary, midscale = 2^(N-1).
- OSR, 16: clock cycles per input sample (≥2).
- ACC_W, N+4: signed integrator width; both integrators saturate at ±(2^(ACC_W-1)-1).
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; dominates all other inputs.
- dataIn  input  N  unsigned sample from the interpolating filter.
- inValid  input  1  dataIn holds a valid sample this cycle.
- inReady  output  1  the block accepts dataIn this cycle; a transfer occurs when inValid && inReady.
- bitOut  output  1  modulator output bit, registered.
- underrun  output  1  one-cycle pulse: a sample slot expired with no transfer.

## Operation

- States: IDLE (no sample held) and RUN.
- Reset values: state=IDLE, phase=0, sample=0, int1=int2=0, bitOut=0, underrun=0; inReady=1 as soon as reset deasserts.
- inReady is combinational: 1 in IDLE, or in RUN when phase==OSR-1; 0 otherwise.
- IDLE:
  - Integrators and bitOut hold their values.
  - On a transfer: sample←dataIn, phase←0, state←RUN. There is no loop update on this edge.
- RUN, every edge:
  - Signed input x = sample − 2^(N-1), range [−2^(N-1), 2^(N-1)−1].
  - Feedback fb = bitOut ? +2^(N-1) : −2^(N-1).
  - int1' = sat(int1 + x − fb).
  - int2' = sat(int2 + int1 − fb), using the old int1.
  - bitOut' = (int2' ≥ 0).
  - The update in a transfer cycle uses the old sample. The new sample takes effect on the next edge.
- Phase counter, RUN:
  - phase increments each edge, 0..OSR−1.
  - At phase==OSR−1 it wraps to 0 whether or not a transfer occurs.
  - A transfer at phase==OSR−1 loads sample←dataIn.
  - No transfer at phase==OSR−1: sample is kept (zero-order hold), underrun←1 for the next cycle only. Otherwise underrun←0.
- Arithmetic:
  - All sums are computed at ACC_W+2 bits, then clamped to ±(2^(ACC_W-1)−1). Integrators never wrap.
  - Steady-state ones density is dataIn/2^N.
- Reset mid-operation: on the next edge every register takes its reset value. The held sample is discarded and state returns to IDLE. A simultaneous inValid is ignored.
- There is no path back from RUN to IDLE other than reset.

## Timing

- Accept-to-effect latency:
  - From IDLE: a sample transferred on edge E0 drives the loop update on E1. The first new bitOut is visible after E1.
  - In RUN: a new sample is first used on the edge after its transfer edge.
- Throughput: exactly one sample per OSR cycles in RUN. inReady is high for one cycle in every OSR.
- underrun rises the cycle after the missed slot, lasts one cycle, and may repeat every OSR cycles.
- inReady does not depend on inValid, so upstream may wait for inReady before asserting inValid.

## Test plan

- **Reset values:** assert reset for 3 cycles with inValid=1 → bitOut=0, underrun=0, inReady=1, and no transfer is taken. Release reset → still IDLE, bitOut holds 0.
- **Exact loop trace:** from reset, transfer dataIn=192 on E0 → bitOut after E1..E6 = 1,1,1,1,1,0; int1 = 192,128,64,0,−64,−128; int2 = 128,192,192,128,0,−192.
- **Ones density:** stream 64, 128, 192 (each held 2048 cycles, inValid always 1) → the ones count over the last 1024 cycles of each is 256±4, 512±4, 768±4. inReady pulses exactly every 16 cycles.
- **Underrun:** in RUN, drop inValid for one slot → underrun is high for exactly one cycle, after the missed phase==15 edge. The previous sample continues to be used. Transfers and density resume normally after the drop.
- **Full-scale saturation:** dataIn=0 and then 255 for 4096 cycles each → int1/int2 stay within ±2047 and never change sign by wrap. Ones count in the last 1024 cycles is ≤8 and ≥1016 respectively.
- **Reset mid-run:** assert reset at phase 7 with inValid=1 → the next edge gives state IDLE, integrators 0, bitOut 0. A new transfer of 192 reproduces the exact loop trace.
